lcd_timing_ctl: RTL and testbench

- Downstream consumer of the LCD pixel FIFO read controller. It generates LCD raster timing: h/v counters, hsync, vsync and data-enable.
- It drives lcd_data_requst one cycle ahead of the active window, so that FIFO read data (one-cycle read latency) lands on the active pixel. It also registers the pixel bus to the panel.
- It flags FIFO underflow and emits a frame-start pulse for the upstream frame source.

---
 rtl/lcd_timing_pkg.sv | 30 +++
 rtl/lcd_timing_ctl_sync_cnt.sv | 56 +++++
 rtl/lcd_timing_ctl.sv | 146 ++++++++++++++
 tb/tb_lcd_timing_ctl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/lcd_timing_pkg.sv
// Shared definitions for the LCD raster timing controller: FSM state encoding,
// default panel timing and helpers used to derive line/frame totals.
package lcd_timing_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;

  localparam int FIFO_CNT_W = 10;

  localparam int DEF_H_SYNC      = 48;
  localparam int DEF_H_BACK      = 40;
  localparam int DEF_H_DISP      = 800;
  localparam int DEF_H_FRONT     = 40;
  localparam int DEF_V_SYNC      = 3;
  localparam int DEF_V_BACK      = 29;
  localparam int DEF_V_DISP      = 480;
  localparam int DEF_V_FRONT     = 13;
  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_START_LEVEL = 256;

  function automatic int lineTotal(input int syncW, input int back, input int disp,
                                   input int front);
    return syncW + back + disp + front;
  endfunction

  localparam int DEF_H_TOTAL = lineTotal(DEF_H_SYNC, DEF_H_BACK, DEF_H_DISP, DEF_H_FRONT);
  localparam int DEF_V_TOTAL = lineTotal(DEF_V_SYNC, DEF_V_BACK, DEF_V_DISP, DEF_V_FRONT);

endpackage

// File: rtl/lcd_timing_ctl_sync_cnt.sv
// Horizontal/vertical raster counters; they advance only while run_i is high
// and sit at zero otherwise.
module lcd_sync_cnt
  import lcd_timing_pkg::*;
#(
  parameter int H_TOTAL = DEF_H_TOTAL,
  parameter int V_TOTAL = DEF_V_TOTAL,
  parameter int HW      = $clog2(H_TOTAL),
  parameter int VW      = $clog2(V_TOTAL)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          run_i,
  output logic [HW-1:0] hCnt_o,
  output logic [VW-1:0] vCnt_o,
  output logic          frameEnd_o
);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  logic [HW-1:0] hCnt_q, hCnt_d;
  logic [VW-1:0] vCnt_q, vCnt_d;
  logic          hLast, vLast;

  assign hLast      = (hCnt_q == H_LAST);
  assign vLast      = (vCnt_q == V_LAST);
  assign frameEnd_o = run_i && hLast && vLast;
  assign hCnt_o     = hCnt_q;
  assign vCnt_o     = vCnt_q;

  always_comb begin
    hCnt_d = hCnt_q;
    vCnt_d = vCnt_q;
    if (!run_i) begin
      hCnt_d = '0;
      vCnt_d = '0;
    end else if (hLast) begin
      hCnt_d = '0;
      vCnt_d = vLast ? '0 : vCnt_q + 1'b1;
    end else begin
      hCnt_d = hCnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hCnt_q <= '0;
      vCnt_q <= '0;
    end else begin
      hCnt_q <= hCnt_d;
      vCnt_q <= vCnt_d;
    end
  end

endmodule

// File: rtl/lcd_timing_ctl.sv
// LCD raster timing generator: frame FSM, sync/active-window decode, FIFO pixel
// request one cycle ahead of the active window, and a two-stage output pipeline.
module lcd_timing_ctl
  import lcd_timing_pkg::*;
#(
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BACK      = DEF_H_BACK,
  parameter int H_DISP      = DEF_H_DISP,
  parameter int H_FRONT     = DEF_H_FRONT,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BACK      = DEF_V_BACK,
  parameter int V_DISP      = DEF_V_DISP,
  parameter int V_FRONT     = DEF_V_FRONT,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int START_LEVEL = DEF_START_LEVEL
) (
  input  logic                  lcd_clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [FIFO_CNT_W-1:0] fifo_rd_cnt,
  input  logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  lcd_data_requst,
  output logic                  lcd_hs,
  output logic                  lcd_vs,
  output logic                  lcd_de,
  output logic [DATA_WIDTH-1:0] lcd_rgb,
  output logic                  frame_start,
  output logic                  underflow
);

  localparam int H_TOTAL = lineTotal(H_SYNC, H_BACK, H_DISP, H_FRONT);
  localparam int V_TOTAL = lineTotal(V_SYNC, V_BACK, V_DISP, V_FRONT);
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_SYNC_E = HW'(H_SYNC);
  localparam logic [HW-1:0] H_ACT_S  = HW'(H_SYNC + H_BACK);
  localparam logic [HW-1:0] H_ACT_E  = HW'(H_SYNC + H_BACK + H_DISP);
  localparam logic [HW-1:0] H_REQ_S  = HW'(H_SYNC + H_BACK - 1);
  localparam logic [HW-1:0] H_REQ_E  = HW'(H_SYNC + H_BACK + H_DISP - 1);
  localparam logic [VW-1:0] V_SYNC_E = VW'(V_SYNC);
  localparam logic [VW-1:0] V_ACT_S  = VW'(V_SYNC + V_BACK);
  localparam logic [VW-1:0] V_ACT_E  = VW'(V_SYNC + V_BACK + V_DISP);
  localparam logic [FIFO_CNT_W-1:0] START_LVL = FIFO_CNT_W'(START_LEVEL);

  logic [1:0]    state_q, state_d;
  logic          run;
  logic [HW-1:0] hCnt;
  logic [VW-1:0] vCnt;
  logic          frameEnd;

  assign run = (state_q == RUN);

  lcd_sync_cnt #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL),
    .HW      (HW),
    .VW      (VW)
  ) u_sync_cnt (
    .clk_i      (lcd_clk),
    .rst_n_i    (rst_n),
    .run_i      (run),
    .hCnt_o     (hCnt),
    .vCnt_o     (vCnt),
    .frameEnd_o (frameEnd)
  );

  // Stopping is only honoured at a frame boundary once RUN is reached.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = FILL;
      FILL: begin
        if (!enable)                       state_d = IDLE;
        else if (fifo_rd_cnt >= START_LVL) state_d = RUN;
      end
      RUN:     if (frameEnd && !enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge lcd_clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  logic hs0, vs0, de0, vAct, hAct, hReq;

  assign vAct = (vCnt >= V_ACT_S) && (vCnt < V_ACT_E);
  assign hAct = (hCnt >= H_ACT_S) && (hCnt < H_ACT_E);
  assign hReq = (hCnt >= H_REQ_S) && (hCnt < H_REQ_E);

  assign hs0             = run ? (hCnt >= H_SYNC_E) : 1'b1;
  assign vs0             = run ? (vCnt >= V_SYNC_E) : 1'b1;
  assign de0             = run && hAct && vAct;
  assign lcd_data_requst = run && hReq && vAct;

  // In any cycle de0, rdEnD1_q, reqD1_q and fifo_rd_data all describe the
  // same pixel, so they travel together through both pipeline stages.
  logic                  rdEnD1_q, reqD1_q;
  logic                  hsD1_q, vsD1_q, deD1_q, pixVldD1_q;
  logic [DATA_WIDTH-1:0] pixD1_q;
  logic                  lcdHs_q, lcdVs_q, lcdDe_q, frameStart_q, underflow_q;
  logic [DATA_WIDTH-1:0] lcdRgb_q;

  always_ff @(posedge lcd_clk or negedge rst_n) begin
    if (!rst_n) begin
      rdEnD1_q     <= 1'b0;
      reqD1_q      <= 1'b0;
      hsD1_q       <= 1'b1;
      vsD1_q       <= 1'b1;
      deD1_q       <= 1'b0;
      pixVldD1_q   <= 1'b0;
      pixD1_q      <= '0;
      lcdHs_q      <= 1'b1;
      lcdVs_q      <= 1'b1;
      lcdDe_q      <= 1'b0;
      lcdRgb_q     <= '0;
      frameStart_q <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      rdEnD1_q     <= fifo_rd_en;
      reqD1_q      <= lcd_data_requst;
      hsD1_q       <= hs0;
      vsD1_q       <= vs0;
      deD1_q       <= de0;
      pixVldD1_q   <= rdEnD1_q;
      pixD1_q      <= fifo_rd_data;
      lcdHs_q      <= hsD1_q;
      lcdVs_q      <= vsD1_q;
      lcdDe_q      <= deD1_q;
      lcdRgb_q     <= (deD1_q && pixVldD1_q) ? pixD1_q : '0;
      frameStart_q <= run && (hCnt == '0) && (vCnt == '0);
      if (reqD1_q && !rdEnD1_q) underflow_q <= 1'b1;
    end
  end

  assign lcd_hs      = lcdHs_q;
  assign lcd_vs      = lcdVs_q;
  assign lcd_de      = lcdDe_q;
  assign lcd_rgb     = lcdRgb_q;
  assign frame_start = frameStart_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_lcd_timing_ctl.sv
// Self-checking bench for lcd_timing_ctl with a small raster (10x6 totals),
// an ideal FIFO read controller with planned misses and a frame-level model.
module tb_lcd_timing_ctl;

  localparam int HT        = 10;
  localparam int VT        = 6;
  localparam int FT        = HT * VT;
  localparam int H_ACT0    = 4;
  localparam int H_ACT1    = 8;
  localparam int V_ACT0    = 2;
  localparam int V_ACT1    = 5;
  localparam int PIX_LINE  = 4;
  localparam int PIX_FRAME = 12;
  localparam int MEM       = 64;

  logic        lcd_clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic [9:0]  fifo_rd_cnt = '0;
  logic        fifo_rd_en = 1'b0;
  logic [15:0] fifo_rd_data = '0;
  logic        lcd_data_requst, lcd_hs, lcd_vs, lcd_de, frame_start, underflow;
  logic [15:0] lcd_rgb;

  int   cyc = 0;
  int   assertCount = 0;
  int   failCount = 0;
  int   runStart = -1;
  int   runEnd = 32'h3fff_ffff;
  int   rdPtr = 0;
  int   reqIdx = 0;
  logic expUflow = 1'b0;
  logic [15:0] pixMem [MEM];
  bit          dropMap [MEM];

  lcd_timing_ctl #(
    .H_SYNC(2), .H_BACK(2), .H_DISP(4), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(1), .V_DISP(3), .V_FRONT(1),
    .DATA_WIDTH(16), .START_LEVEL(4)
  ) dut (
    .lcd_clk         (lcd_clk),
    .rst_n           (rst_n),
    .enable          (enable),
    .fifo_rd_cnt     (fifo_rd_cnt),
    .fifo_rd_en      (fifo_rd_en),
    .fifo_rd_data    (fifo_rd_data),
    .lcd_data_requst (lcd_data_requst),
    .lcd_hs          (lcd_hs),
    .lcd_vs          (lcd_vs),
    .lcd_de          (lcd_de),
    .lcd_rgb         (lcd_rgb),
    .frame_start     (frame_start),
    .underflow       (underflow)
  );

  always #5 lcd_clk = ~lcd_clk;

  // Raster position of the counters during bench cycle k.
  function automatic bit running(int k);
    return (runStart >= 0) && (k >= runStart) && (k <= runEnd);
  endfunction
  function automatic int hOf(int k);
    return (k - runStart) % HT;
  endfunction
  function automatic int vOf(int k);
    return ((k - runStart) / HT) % VT;
  endfunction
  function automatic bit vActAt(int k);
    return (vOf(k) >= V_ACT0) && (vOf(k) < V_ACT1);
  endfunction
  function automatic bit deAt(int k);
    if (!running(k)) return 1'b0;
    return vActAt(k) && (hOf(k) >= H_ACT0) && (hOf(k) < H_ACT1);
  endfunction
  function automatic bit reqAt(int k);
    if (!running(k)) return 1'b0;
    return vActAt(k) && (hOf(k) >= H_ACT0 - 1) && (hOf(k) < H_ACT1 - 1);
  endfunction
  function automatic bit hsAt(int k);
    return !running(k) || (hOf(k) >= 2);
  endfunction
  function automatic bit vsAt(int k);
    return !running(k) || (vOf(k) >= 1);
  endfunction
  function automatic bit fsAt(int k);
    return running(k) && (hOf(k) == 0) && (vOf(k) == 0);
  endfunction
  function automatic int ordOf(int k);
    return ((k - runStart) / FT) * PIX_FRAME + (vOf(k) - V_ACT0) * PIX_LINE + (hOf(k) - H_ACT0);
  endfunction

  // A missed pixel shows 0; every other pixel shows the next unread FIFO word.
  function automatic logic [15:0] pixelValue(int ord);
    int reads;
    reads = 0;
    if (ord >= MEM || dropMap[ord]) return 16'h0000;
    for (int i = 0; i < ord; i++) if (!dropMap[i]) reads++;
    return pixMem[reads];
  endfunction

  task automatic checkVal(input string tag, input logic [15:0] got, input logic [15:0] exp);
    assertCount++;
    assert (got === exp) else begin
      failCount++;
      $error("[TB] FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  // Ideal read controller: reads on every request unless that pixel is planned as a miss.
  task automatic applyStimulus();
    @(posedge lcd_clk);
    cyc++;
    #1;
    if (fifo_rd_en) begin
      fifo_rd_data = pixMem[rdPtr];
      rdPtr++;
    end
    fifo_rd_en = lcd_data_requst && !(reqIdx < MEM && dropMap[reqIdx]);
    if (lcd_data_requst) reqIdx++;
  endtask

  task automatic checkOutput();
    logic [15:0] expRgb;
    int ord;
    if (deAt(cyc - 1)) begin
      ord = ordOf(cyc - 1);
      if (ord < MEM && dropMap[ord]) expUflow = 1'b1;
    end
    expRgb = deAt(cyc - 2) ? pixelValue(ordOf(cyc - 2)) : 16'h0000;
    checkVal("req", {15'b0, lcd_data_requst}, {15'b0, reqAt(cyc)});
    checkVal("hs", {15'b0, lcd_hs}, {15'b0, hsAt(cyc - 2)});
    checkVal("vs", {15'b0, lcd_vs}, {15'b0, vsAt(cyc - 2)});
    checkVal("de", {15'b0, lcd_de}, {15'b0, deAt(cyc - 2)});
    checkVal("rgb", lcd_rgb, expRgb);
    checkVal("frame_start", {15'b0, frame_start}, {15'b0, fsAt(cyc - 1)});
    checkVal("underflow", {15'b0, underflow}, {15'b0, expUflow});
  endtask

  task automatic runCycles(input int n);
    repeat (n) begin
      applyStimulus();
      @(negedge lcd_clk);
      checkOutput();
    end
  endtask

  initial begin
    for (int i = 0; i < MEM; i++) begin
      pixMem[i]  = (i < PIX_FRAME) ? 16'(i + 1) : 16'($urandom_range(1, 65535));
      dropMap[i] = 1'b0;
    end
    dropMap[PIX_FRAME + 1] = 1'b1;
    for (int i = 2 * PIX_FRAME; i < 3 * PIX_FRAME; i++)
      dropMap[i] = ($urandom_range(0, 3) == 0);

    #2 rst_n = 1'b0;
    runCycles(3);
    rst_n = 1'b1;

    // Below the start level the FSM must wait in FILL.
    enable = 1'b1;
    fifo_rd_cnt = 10'd3;
    runCycles(20);

    fifo_rd_cnt = 10'd4;
    runStart = cyc + 1;
    runCycles(180);

    runCycles(runStart + 185 - cyc);
    rst_n = 1'b0;
    #1;
    checkVal("rst_hs", {15'b0, lcd_hs}, 16'h0001);
    checkVal("rst_vs", {15'b0, lcd_vs}, 16'h0001);
    checkVal("rst_de", {15'b0, lcd_de}, 16'h0000);
    checkVal("rst_rgb", lcd_rgb, 16'h0000);
    checkVal("rst_req", {15'b0, lcd_data_requst}, 16'h0000);
    checkVal("rst_underflow", {15'b0, underflow}, 16'h0000);
    checkVal("rst_frame_start", {15'b0, frame_start}, 16'h0000);
    runStart = -1;
    expUflow = 1'b0;
    rdPtr = 0;
    reqIdx = 0;
    fifo_rd_en = 1'b0;
    enable = 1'b0;
    fifo_rd_cnt = 10'd0;
    runCycles(2);
    rst_n = 1'b1;
    runCycles(2);

    // Start level reached in the same cycle enable drops: IDLE wins.
    enable = 1'b1;
    runCycles(3);
    fifo_rd_cnt = 10'd4;
    enable = 1'b0;
    runCycles(5);

    enable = 1'b1;
    runStart = cyc + 2;
    runCycles(runStart + 30 - cyc);
    enable = 1'b0;
    runEnd = runStart + FT - 1;
    runCycles(100);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
